// File: rtl/hd_pattern_pkg.sv
// ============================================================================
// Module   : hd_pattern_pkg
// Purpose  : Shared types and constants for the HD test-pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hd_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_GRAD  = 2'd3
  } pat_mode_e;

  localparam int PKG_COLOR_W = 4;

  typedef struct packed {
    logic [PKG_COLOR_W-1:0] red;
    logic [PKG_COLOR_W-1:0] green;
    logic [PKG_COLOR_W-1:0] blue;
  } rgb_t;

  // {r,g,b} masks, bar 0 in the least significant triplet
  localparam logic [23:0] C_BAR_TABLE = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    return C_BAR_TABLE[int'(idx)*3 +: 3];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hd_frame_timer.sv
// ============================================================================
// Module   : hd_frame_timer
// Purpose  : End-of-frame detect, frame divider, colour index and frame tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hd_frame_timer
  import hd_pattern_pkg::*;
#(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter int H_W       = 11,
  parameter int V_W       = 10,
  parameter int FRAME_DIV = 32
) (
  input  logic           pixel_clk,
  input  logic           rst_n,
  input  logic [H_W-1:0] i_h_coord,
  input  logic [V_W-1:0] i_v_coord,
  output logic           o_eof,
  output logic [1:0]     o_ci,
  output logic           o_frame_tick
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_frame_cnt;
  logic [1:0]       r_ci;
  logic             r_frame_tick;
  logic             w_eof;

  // Only the exact last active pixel counts; blanking coordinates never match
  assign w_eof = (i_h_coord == H_W'(H_ACTIVE - 1)) &&
                 (i_v_coord == V_W'(V_ACTIVE - 1));

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_frame_cnt  <= '0;
      r_ci         <= 2'd0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_eof;
      if (w_eof) begin
        if (r_frame_cnt == C_CNT_LAST) begin
          r_frame_cnt <= '0;
          r_ci        <= (r_ci == 2'd2) ? 2'd0 : r_ci + 2'd1;
        end else begin
          r_frame_cnt <= r_frame_cnt + C_CNT_ONE;
        end
      end
    end
  end

  assign o_eof        = w_eof;
  assign o_ci         = r_ci;
  assign o_frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: rtl/hd_pattern_gen.sv
// ============================================================================
// Module   : hd_pattern_gen
// Purpose  : Four-mode VGA test-pattern generator with registered RGB output.
// Options  : HD_PATTERN_BORDER_EN - force a full-scale white active-area border
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hd_pattern_gen
  import hd_pattern_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int H_W        = 11,
  parameter int V_W        = 10,
  parameter int COLOR_W    = 4,
  parameter int LEVEL      = 8,
  parameter int FRAME_DIV  = 32,
  parameter int CELL_LOG   = 5,
  parameter int GRAD_SHIFT = 6
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic [H_W-1:0]     h_coord,
  input  logic [V_W-1:0]     v_coord,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_tick
);

  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int GRAD_MAX = (2 ** COLOR_W) - 1;
  localparam logic [COLOR_W-1:0] C_FULL  = '1;
  localparam logic [COLOR_W-1:0] C_LEVEL = COLOR_W'(LEVEL);

  logic               w_eof;
  logic [1:0]         w_ci;
  pat_mode_e          r_mode_q;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;

  logic               w_active;
  logic [H_W-1:0]     w_bar_div;
  logic [2:0]         w_bar_idx;
  logic [2:0]         w_bar_mask;
  logic [H_W-1:0]     w_grad;
  logic [COLOR_W-1:0] w_grad_sat;
  logic               w_check;
  logic [COLOR_W-1:0] w_red;
  logic [COLOR_W-1:0] w_green;
  logic [COLOR_W-1:0] w_blue;

  hd_frame_timer #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .H_W       (H_W),
    .V_W       (V_W),
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_timer (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .i_h_coord    (h_coord),
    .i_v_coord    (v_coord),
    .o_eof        (w_eof),
    .o_ci         (w_ci),
    .o_frame_tick (frame_tick)
  );

  assign w_active = (int'(h_coord) < H_ACTIVE) && (int'(v_coord) < V_ACTIVE);

  // Clamp and saturate on the full-width value before narrowing
  assign w_bar_div  = h_coord / H_W'(BAR_W);
  assign w_bar_idx  = (w_bar_div > H_W'(7)) ? 3'd7 : w_bar_div[2:0];
  assign w_bar_mask = bar_mask(w_bar_idx);

  assign w_grad     = h_coord >> GRAD_SHIFT;
  assign w_grad_sat = (int'(w_grad) > GRAD_MAX) ? C_FULL : COLOR_W'(w_grad);

  assign w_check    = h_coord[CELL_LOG] ^ v_coord[CELL_LOG];

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    unique case (r_mode_q)
      PAT_SOLID: begin
        case (w_ci)
          2'd0:    w_red   = C_LEVEL;
          2'd1:    w_green = C_LEVEL;
          2'd2:    w_blue  = C_LEVEL;
          default: w_red   = '0;
        endcase
      end
      PAT_BARS: begin
        w_red   = {COLOR_W{w_bar_mask[2]}};
        w_green = {COLOR_W{w_bar_mask[1]}};
        w_blue  = {COLOR_W{w_bar_mask[0]}};
      end
      PAT_CHECK: begin
        w_red   = {COLOR_W{w_check}};
        w_green = {COLOR_W{w_check}};
        w_blue  = {COLOR_W{w_check}};
      end
      PAT_GRAD: begin
        w_red   = w_grad_sat;
        w_green = w_grad_sat;
        w_blue  = w_grad_sat;
      end
    endcase
`ifdef HD_PATTERN_BORDER_EN
    if ((h_coord == '0) || (h_coord == H_W'(H_ACTIVE - 1)) ||
        (v_coord == '0) || (v_coord == V_W'(V_ACTIVE - 1))) begin
      w_red   = C_FULL;
      w_green = C_FULL;
      w_blue  = C_FULL;
    end
`endif
    if (!w_active) begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
    end
  end

  // mode_q changes only on the eof edge so a frame is never split between patterns
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_mode_q <= PAT_SOLID;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
    end else begin
      if (w_eof) begin
        r_mode_q <= pat_mode_e'(mode);
      end
      r_red   <= w_red;
      r_green <= w_green;
      r_blue  <= w_blue;
    end
  end

  assign red   = r_red;
  assign green = r_green;
  assign blue  = r_blue;

endmodule

`default_nettype wire

// File: tb/tb_hd_pattern_gen.sv
// ============================================================================
// Module   : tb_hd_pattern_gen
// Purpose  : Scoreboard bench for hd_pattern_gen at default geometry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hd_pattern_gen;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic [1:0]  mode;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        frame_tick;

  always #5 pixel_clk = ~pixel_clk;

  hd_pattern_gen dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .h_coord    (h_coord),
    .v_coord    (v_coord),
    .mode       (mode),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        tick;
    logic [15:0] id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  // Solid-cycle colour after f end-of-frames since reset: 32 frames per step
  function automatic logic [11:0] solid(input int f);
    case ((f / 32) % 3)
      0:       return 12'h800;
      1:       return 12'h080;
      default: return 12'h008;
    endcase
  endfunction

  // Drive one pixel at the falling edge and queue the response due after the next rising edge
  task automatic px(input int h, input int v, input logic [1:0] m, input logic rn,
                    input logic [11:0] rgb, input logic tk);
    exp_t e;
    @(negedge pixel_clk);
    h_coord = 11'(h);
    v_coord = 10'(v);
    mode    = m;
    rst_n   = rn;
`ifdef HD_PATTERN_BORDER_EN
    if (rn && h < 800 && v < 600 && (h == 0 || h == 799 || v == 0 || v == 599))
      rgb = 12'hFFF;
`endif
    e.r    = rgb[11:8];
    e.g    = rgb[7:4];
    e.b    = rgb[3:0];
    e.tick = tk;
    e.id   = 16'(vec_id);
    vec_id++;
    sb.push_back(e);
  endtask

  // Monitor: every output cycle that has a queued expectation is compared
  initial begin
    forever begin
      @(posedge pixel_clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({red, green, blue} !== {e.r, e.g, e.b}) begin
          errors++;
          $display("FAIL vec%0d rgb got=%h/%h/%h want=%h/%h/%h",
                   e.id, red, green, blue, e.r, e.g, e.b);
        end
        checks++;
        if (frame_tick !== e.tick) begin
          errors++;
          $display("FAIL vec%0d frame_tick got=%b want=%b", e.id, frame_tick, e.tick);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    h_coord = '0;
    v_coord = '0;
    mode    = 2'd0;

    px(0, 0, 2'd0, 1'b0, 12'h000, 1'b0);

    // Frames 0..39 solid; last eof requests gradient for frame 40
    for (int i = 0; i < 40; i++) begin
      px(0, 0, 2'd0, 1'b1, solid(i), 1'b0);
      px(799, 599, (i == 39) ? 2'd3 : 2'd0, 1'b1, solid(i), 1'b1);
    end
    // Frame 40: gradient, one-cycle reset, then mode 0 red from ci 0
    px(128, 100, 2'd3, 1'b1, 12'h222, 1'b0);
    px(200, 100, 2'd3, 1'b0, 12'h000, 1'b0);
    px(300, 100, 2'd3, 1'b1, 12'h800, 1'b0);

    // 97 frames of solid cycle counted from the reset
    for (int i = 0; i < 97; i++) begin
      px(0, 0, 2'd0, 1'b1, solid(i), 1'b0);
      px(400, 300, 2'd0, 1'b1, solid(i), 1'b0);
      if (i == 5) begin
        px(800, 0, 2'd0, 1'b1, 12'h000, 1'b0);
        px(799, 600, 2'd0, 1'b1, 12'h000, 1'b0);
      end
      px(799, 599, 2'd0, 1'b1, solid(i), 1'b1);
    end

    // Frame 97 solid, request bars
    px(0, 0, 2'd1, 1'b1, solid(97), 1'b0);
    px(799, 599, 2'd1, 1'b1, solid(97), 1'b1);
    // Frame 98 bars
    px(0, 10, 2'd1, 1'b1, 12'hFFF, 1'b0);
    px(100, 10, 2'd1, 1'b1, 12'hFF0, 1'b0);
    px(250, 10, 2'd1, 1'b1, 12'h0FF, 1'b0);
    px(450, 599, 2'd1, 1'b1, 12'hF0F, 1'b0);
    px(700, 10, 2'd1, 1'b1, 12'h000, 1'b0);
    px(799, 10, 2'd1, 1'b1, 12'h000, 1'b0);
    px(799, 599, 2'd2, 1'b1, 12'h000, 1'b1);
    // Frame 99 checker; mid-frame mode change ignored
    px(0, 0, 2'd2, 1'b1, 12'h000, 1'b0);
    px(32, 0, 2'd2, 1'b1, 12'hFFF, 1'b0);
    px(32, 32, 2'd0, 1'b1, 12'h000, 1'b0);
    px(64, 32, 2'd0, 1'b1, 12'hFFF, 1'b0);
    px(799, 599, 2'd3, 1'b1, 12'h000, 1'b1);
    // Frame 100 gradient
    px(0, 0, 2'd3, 1'b1, 12'h000, 1'b0);
    px(64, 10, 2'd3, 1'b1, 12'h111, 1'b0);
    px(799, 10, 2'd3, 1'b1, 12'hCCC, 1'b0);
    px(1000, 10, 2'd3, 1'b1, 12'h000, 1'b0);
    px(799, 599, 2'd0, 1'b1, 12'hCCC, 1'b1);
    // Frame 101 solid; switch to checker at v=300 takes effect next frame
    px(10, 100, 2'd0, 1'b1, solid(101), 1'b0);
    px(10, 300, 2'd2, 1'b1, solid(101), 1'b0);
    px(500, 450, 2'd2, 1'b1, solid(101), 1'b0);
    px(799, 599, 2'd2, 1'b1, solid(101), 1'b1);
    // Frame 102 checker from its first pixel
    px(0, 0, 2'd2, 1'b1, 12'h000, 1'b0);
    px(32, 0, 2'd2, 1'b1, 12'hFFF, 1'b0);

    repeat (3) @(posedge pixel_clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got=%0d want=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hd_pattern_gen.md
# hd_pattern_gen

Parametrised VGA test-pattern generator, the next generation of the two-colour frame-alternating test block. It sits between the sync/coordinate generator and the VGA DAC pins and drives registered RGB from the current pixel coordinates. It supports four selectable patterns: solid colour cycle, colour bars, checkerboard and grey gradient. Pattern changes are frame-synchronous, and the frame divider and geometry are generic.

## Interface
- H_ACTIVE, 800: active pixels per line.
- V_ACTIVE, 600: active lines per frame.
- H_W, 11: h_coord width.
- V_W, 10: v_coord width.
- COLOR_W, 4: bits per colour channel.
- LEVEL, 8: channel intensity used in solid-cycle mode.
- FRAME_DIV, 32: frames per solid-colour step; must be ≥ 1.
- CELL_LOG, 5: checker cell size is 2^CELL_LOG pixels.
- GRAD_SHIFT, 6: gradient level is h_coord >> GRAD_SHIFT.

Ports:
- pixel_clk, in, 1: pixel clock.
- rst_n, in, 1: reset, synchronous, active-low.
- h_coord, in, H_W: current horizontal coordinate.
- v_coord, in, V_W: current vertical coordinate.
- mode, in, 2: requested pattern (0 solid cycle, 1 bars, 2 checker, 3 gradient).
- red, out, COLOR_W: registered red channel.
- green, out, COLOR_W: registered green channel.
- blue, out, COLOR_W: registered blue channel.
- frame_tick, out, 1: one-cycle pulse registered at end of frame.

## Operation
- End of frame (eof) is true when h_coord == H_ACTIVE-1 and v_coord == V_ACTIVE-1.
- Active area is h_coord < H_ACTIVE and v_coord < V_ACTIVE. Outside it, all channels are 0 in every mode.
- The mode input is sampled into mode_q only on eof. A mid-frame change has no effect until the next frame.
- Frame counter, $clog2(FRAME_DIV) bits (minimum 1):
  - Increments on eof.
  - On eof with count == FRAME_DIV-1, it wraps to 0 and colour index ci advances.
  - ci steps 0→1→2→0.
  - Counter and ci run in all modes.
- Mode 0 (solid cycle): ci 0 gives red=LEVEL, ci 1 gives green=LEVEL, ci 2 gives blue=LEVEL. Other channels are 0.
- Mode 1 (bars): 8 bars of width BAR_W = H_ACTIVE/8; bar index is h_coord/BAR_W, clamped to 7.
  - Colours are full-scale (all ones) or 0 per channel.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
- Mode 2 (checker): if h_coord[CELL_LOG] ^ v_coord[CELL_LOG] is 1, output white full-scale; otherwise black.
- Mode 3 (gradient): g = h_coord >> GRAD_SHIFT, saturated to 2^COLOR_W-1. All three channels equal g.
- Arithmetic is unsigned. Saturation and clamps are applied before truncation to COLOR_W.

## Timing
- Latency is 1 cycle: outputs at edge n+1 reflect the coordinates and mode_q at edge n.
- frame_tick is high for the one cycle after the edge that samples eof.
- mode_q, frame counter and ci all update on the same edge as the eof sample. The first pixel of the next frame uses the new values.
- Reset values: red, green, blue = 0; frame_tick = 0; mode_q = 0; frame counter = 0; ci = 0.
- Reset asserted mid-frame clears all state on the next edge. After release, output resumes from the current coordinates in mode 0 with ci = 0.
- FRAME_DIV == 1: ci advances on every eof.
- Coordinates outside the frame never produce eof and never wrap the counter.

## Configuration
- HD_PATTERN_BORDER_EN defined: active-area pixels with h_coord == 0, h_coord == H_ACTIVE-1, v_coord == 0 or v_coord == V_ACTIVE-1 output full-scale white in every mode, overriding the pattern. Latency is unchanged.
- HD_PATTERN_BORDER_EN undefined: no override; edge pixels follow the pattern.

## Structure
- Package hd_pattern_pkg holds:
  - the mode enum (PAT_SOLID, PAT_BARS, PAT_CHECK, PAT_GRAD);
  - an rgb_t struct parametrised by COLOR_W through a localparam;
  - the 8-entry bar colour constant table as 3-bit RGB masks.
- Sub-module hd_frame_timer contains the eof detect, frame counter, ci and frame_tick. The top block holds mode_q, pattern muxing and output registers.

## Test plan
- Defaults, hold mode=0 and run 96 frames. Expect red=8 for frames 0–31, green=8 for 32–63, blue=8 for 64–95, then red again. frame_tick pulses 96 times.
- mode=1 in frame 0, bars checked in frame 1. h=0 → F,F,F; h=100 → F,F,0 (yellow); h=700 → 0,0,0. Each colour appears 1 cycle after its coordinate.
- mode=2: (0,0) → black; (32,0) → white; (32,32) → black.
- mode=3: h=0 → 0,0,0; h=64 → 1,1,1; h=799 → 12,12,12.
- Switch mode from 0 to 2 at v=300 mid-frame. Pattern stays solid until eof, and checker starts at (0,0) of the next frame.
- Assert rst_n low for 1 cycle during frame 40. Outputs are 0 on the next cycle, then mode 0 red resumes. Build with HD_PATTERN_BORDER_EN and check h=0 and v=599 are white in mode 1.
